// File: rtl/risc16_mmio_uart.sv
// risc16_mmio_uart: memory-mapped I/O slave for the risc16p data bus.
// Decodes 0x0200-0x020F and provides a 24-bit LED register plus a transmit-only
// 8N1 UART with a holding buffer.
// Optional build macro RISC16_MMIO_TXFIFO_EN: when defined, the holding buffer
// is a 4-entry FIFO; otherwise it is a single holding register.
module risc16_mmio_uart #(
  parameter int CLK_HZ = 25_000_000,
  parameter int BAUD   = 115200
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] daddr,
  input  logic [15:0] ddout,
  input  logic        dwe,
  input  logic        doe,
  output logic        mmio_sel,
  output logic [15:0] mmio_rdata,
  output logic [23:0] led,
  output logic        uart_tx
);

  localparam int DIV = CLK_HZ / BAUD;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] DIV_M1 = CW'(DIV - 1);

  if (DIV < 2) begin : g_div_chk
    $error("risc16_mmio_uart: CLK_HZ / BAUD must be at least 2");
  end

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_baud, w_baud_nxt;
  logic [2:0]      r_bit, w_bit_nxt;
  logic [7:0]      r_shift, w_shift_nxt;
  logic            r_tx, w_tx_nxt;
  logic [23:0]     r_led;
  logic            r_ovf;

  logic            w_sel, w_wr, w_push_req, w_push, w_pop;
  logic            w_full, w_empty, w_busy, w_tick;
  logic [2:0]      w_reg;
  logic [7:0]      w_head;
  logic            w_unused;

  assign w_sel      = (daddr[15:4] == 12'h020);
  assign w_reg      = daddr[3:1];
  assign w_unused   = daddr[0];
  assign w_wr       = dwe & w_sel;
  assign w_push_req = w_wr & (w_reg == 3'd2);
  // A write while full is dropped even if the FSM pops in the same cycle.
  assign w_push     = w_push_req & ~w_full;
  assign w_tick     = (r_baud == '0);
  assign w_busy     = (r_state != S_IDLE) | ~w_empty;

`ifdef RISC16_MMIO_TXFIFO_EN
  logic [7:0] r_mem [4];
  logic [1:0] r_wp, r_rp;
  logic [2:0] r_cnt;

  assign w_full  = (r_cnt == 3'd4);
  assign w_empty = (r_cnt == 3'd0);
  assign w_head  = r_mem[r_rp];

  // FIFO storage: data only, no reset needed.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= ddout[7:0];
  end

  // FIFO pointers and occupancy; pointers wrap naturally modulo 4.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 2'd1;
      if (w_pop)  r_rp <= r_rp + 2'd1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 3'd1;
        2'b01:   r_cnt <= r_cnt - 3'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end
`else
  logic [7:0] r_hold;
  logic       r_hv;

  assign w_full  = r_hv;
  assign w_empty = ~r_hv;
  assign w_head  = r_hold;

  // Holding register contents: data only, no reset needed.
  always_ff @(posedge clk) begin
    if (w_push) r_hold <= ddout[7:0];
  end

  // Holding register valid bit; push and pop never coincide (push needs it clear).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_hv <= 1'b0;
    else if (w_push) r_hv <= 1'b1;
    else if (w_pop)  r_hv <= 1'b0;
  end
`endif

  // LED register writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_led <= '0;
    end else if (w_wr && (w_reg == 3'd0)) begin
      r_led[15:0] <= ddout;
    end else if (w_wr && (w_reg == 3'd1)) begin
      r_led[23:16] <= ddout[7:0];
    end
  end

  // Sticky overflow flag: set by a dropped TXDATA write, cleared by any STATUS write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            r_ovf <= 1'b0;
    else if (w_push_req && w_full)         r_ovf <= 1'b1;
    else if (w_wr && (w_reg == 3'd3))      r_ovf <= 1'b0;
  end

  // UART next-state logic; serial bit is a registered function of the current state.
  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_pop       = 1'b0;
    w_tx_nxt    = 1'b1;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_shift_nxt = w_head;
          w_baud_nxt  = DIV_M1;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        w_tx_nxt = 1'b0;
        if (w_tick) begin
          w_baud_nxt  = DIV_M1;
          w_bit_nxt   = 3'd0;
          w_state_nxt = S_DATA;
        end else begin
          w_baud_nxt = r_baud - CW'(1);
        end
      end
      S_DATA: begin
        w_tx_nxt = r_shift[0];
        if (w_tick) begin
          w_baud_nxt  = DIV_M1;
          w_shift_nxt = {1'b0, r_shift[7:1]};
          if (r_bit == 3'd7) w_state_nxt = S_STOP;
          else               w_bit_nxt   = r_bit + 3'd1;
        end else begin
          w_baud_nxt = r_baud - CW'(1);
        end
      end
      S_STOP: begin
        if (w_tick) begin
          if (!w_empty) begin
            // Chain straight into the next frame with no idle cycle.
            w_pop       = 1'b1;
            w_shift_nxt = w_head;
            w_baud_nxt  = DIV_M1;
            w_state_nxt = S_START;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_baud_nxt = r_baud - CW'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // UART control state and registered serial output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_baud  <= w_baud_nxt;
      r_bit   <= w_bit_nxt;
      r_tx    <= w_tx_nxt;
    end
  end

  // Transmit shift register: data only, no reset needed.
  always_ff @(posedge clk) begin
    r_shift <= w_shift_nxt;
  end

  // Zero-latency read mux, forced to 0 outside the window or without a read strobe.
  always_comb begin
    mmio_rdata = 16'h0000;
    if (doe && w_sel) begin
      case (w_reg)
        3'd0:    mmio_rdata = r_led[15:0];
        3'd1:    mmio_rdata = {8'h00, r_led[23:16]};
        3'd3:    mmio_rdata = {13'b0, r_ovf, w_full, w_busy};
        default: mmio_rdata = 16'h0000;
      endcase
    end
  end

  assign mmio_sel = w_sel;
  assign led      = r_led;
  assign uart_tx  = r_tx;

endmodule
